// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: load/store unit state encoding and timeout default
package cpu_pkg;

  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_ISSUE = 2'd1,
    LS_WAIT  = 2'd2,
    LS_DONE  = 2'd3
  } ls_state_t;

  localparam int LS_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/ls_unit_if.sv
// rtl/ls_unit_if.sv - synchronous memory/IO port with ready acknowledge
interface ls_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/ls_timeout_ctr.sv
// rtl/ls_timeout_ctr.sv - WAIT-state watchdog counter; tc flags that this increment reaches TIMEOUT
module ls_timeout_ctr #(
  parameter int  TIMEOUT = 15,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Raised one count early so the FSM leaves WAIT on the TIMEOUT-th idle cycle.
  assign tc = (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/ls_unit.sv
// rtl/ls_unit.sv - load/store unit between the control FSM and the memory/IO port
// Optional WAIT watchdog with error completion is built when LS_TIMEOUT_EN is defined.
module ls_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
`ifdef LS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = LS_TIMEOUT_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [15:0]       ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_busy,
  output logic              ls_done,
  output logic              ls_err,
  output logic [DATA_W-1:0] ls_rdata,
  ls_unit_if.master         mem
);
  ls_state_t         state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              ready_hit;
  logic              timed_out;

  assign accept    = (state_q == LS_IDLE) && ls_req;
  assign ready_hit = (state_q == LS_WAIT) && mem.mem_ready;

`ifdef LS_TIMEOUT_EN
  logic tc;
  logic err_q;

  ls_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == LS_ISSUE),
    .enable ((state_q == LS_WAIT) && !mem.mem_ready),
    .tc     (tc)
  );

  // A ready arriving on the terminal cycle still completes successfully.
  assign timed_out = (state_q == LS_WAIT) && !mem.mem_ready && tc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == LS_WAIT) begin
      err_q <= timed_out;
    end
  end

  assign ls_err = err_q && (state_q == LS_DONE);
`else
  assign timed_out = 1'b0;
  assign ls_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      LS_IDLE:  if (ls_req) state_d = LS_ISSUE;
      LS_ISSUE: state_d = LS_WAIT;
      LS_WAIT:  if (ready_hit || timed_out) state_d = LS_DONE;
      LS_DONE:  state_d = LS_IDLE;
      default:  state_d = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= ls_we;
      addr_q  <= ls_addr[ADDR_W-1:0];
      wdata_q <= ls_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (ready_hit && !we_q) begin
      rdata_q <= mem.mem_rdata;
    end
  end

  // Strobes decode from state alone so reset drops them without a clock.
  assign mem.mem_en    = (state_q == LS_ISSUE);
  assign mem.mem_we    = (state_q == LS_ISSUE) && we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign ls_busy  = (state_q != LS_IDLE);
  assign ls_done  = (state_q == LS_DONE);
  assign ls_rdata = rdata_q;
endmodule

// File: tb/tb_ls_unit.sv
// tb/tb_ls_unit.sv - directed scoreboard bench for ls_unit
module tb_ls_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        ls_busy, ls_done, ls_err;
  logic [15:0] ls_rdata;

  ls_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  ls_unit dut (
    .clk      (clk),
    .reset    (reset),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_busy  (ls_busy),
    .ls_done  (ls_done),
    .ls_err   (ls_err),
    .ls_rdata (ls_rdata),
    .mem      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is IDLE. delay < 0 means ready never comes.
  task automatic run_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                            input logic [15:0] rd, input int delay, input int exp_lat,
                            input logic exp_err, input bit pulse);
    exp_t e;
    int   lat;
    bit   seen;
    if (!we && !exp_err) model_rdata = rd;
    e.rdata = model_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
    @(negedge clk);
    ls_req = 1'b0; ls_we = ~we; ls_addr = ~addr; ls_wdata = ~wd;
    chk("issue_en", bus.mem_en, 1);
    chk("issue_we", bus.mem_we, we);
    chk("issue_addr", bus.mem_addr, addr);
    chk("issue_wdata", bus.mem_wdata, wd);
    chk("issue_busy", ls_busy, 1);
    lat = 1;
    seen = 0;
    while (!seen && lat < 60) begin
      bus.mem_ready = (delay >= 0) && (lat == delay + 2);
      bus.mem_rdata = bus.mem_ready ? rd : ~rd;
      ls_req = pulse && (lat == 3);
      @(negedge clk);
      lat++;
      bus.mem_ready = 1'b0;
      ls_req = 1'b0;
      if (ls_done) seen = 1;
      else if (lat == 3) begin
        chk("wait_en", bus.mem_en, 0);
        chk("wait_addr", bus.mem_addr, addr);
      end
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, exp_lat);
    e = sb.pop_front();
    chk("rdata", ls_rdata, e.rdata);
    chk("err", ls_err, e.err);
    @(negedge clk);
    chk("done_one_cycle", ls_done, 0);
    chk("idle_busy", ls_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   en_cyc[2];
    int   n_en, n_done;
    bit   respond;

    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", ls_busy, 0);
    chk("rst_done", ls_done, 0);
    chk("rst_err", ls_err, 0);
    chk("rst_en", bus.mem_en, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_rdata", ls_rdata, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    reset = 1'b1;
    @(negedge clk);

    run_access(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 0, 3, 1'b0, 0);
    run_access(1'b1, 16'h0040, 16'h1234, 16'h9999, 3, 6, 1'b0, 0);

    // Two loads with ls_req held high throughout.
    sb.push_back({16'hAAAA, 1'b0});
    sb.push_back({16'h5555, 1'b0});
    model_rdata = 16'h5555;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100;
    n_en = 0; n_done = 0; respond = 0;
    for (int k = 0; k < 20 && n_done < 2; k++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (respond) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = (n_en == 1) ? 16'hAAAA : 16'h5555;
        respond = 0;
      end
      if (bus.mem_en) begin
        if (n_en < 2) en_cyc[n_en] = cyc;
        n_en++;
        respond = 1;
        if (n_en == 2) begin
          chk("b2b_addr2", bus.mem_addr, 16'h0101);
          ls_req = 1'b0;
        end
        ls_addr = 16'h0101;
      end
      if (ls_done) begin
        e = sb.pop_front();
        chk("b2b_rdata", ls_rdata, e.rdata);
        n_done++;
      end
    end
    bus.mem_ready = 1'b0;
    ls_req = 1'b0;
    chk("b2b_accepts", n_en, 2);
    chk("b2b_dones", n_done, 2);
    chk("b2b_period", en_cyc[1] - en_cyc[0], 4);
    @(negedge clk);

    // Request pulse inside WAIT must not start another access.
    run_access(1'b0, 16'h0077, 16'h0000, 16'h0F0F, 4, 7, 1'b0, 1);
    n_en = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_en) n_en++;
    end
    chk("wait_pulse_ignored", n_en, 0);

`ifdef LS_TIMEOUT_EN
    run_access(1'b0, 16'h0021, 16'h0000, 16'hDEAD, -1, 17, 1'b1, 0);
    run_access(1'b0, 16'h0022, 16'h0000, 16'h1357, 14, 17, 1'b0, 0);
`else
    run_access(1'b0, 16'h0023, 16'h0000, 16'h1357, 20, 23, 1'b0, 0);
`endif

    // Reset during WAIT aborts the load with no completion.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0033;
    @(negedge clk);
    ls_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", ls_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_en", bus.mem_en, 0);
    chk("arst_we", bus.mem_we, 0);
    chk("arst_busy", ls_busy, 0);
    chk("arst_rdata", ls_rdata, 0);
    @(negedge clk);
    chk("arst_no_done", ls_done, 0);
    reset = 1'b1;
    model_rdata = '0;

    // Reset during ISSUE of a store drops the write strobe immediately.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0034; ls_wdata = 16'h4321;
    @(negedge clk);
    ls_req = 1'b0;
    chk("pre_rst_we", bus.mem_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_issue_we", bus.mem_we, 0);
    chk("arst_issue_en", bus.mem_en, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_access(1'b0, 16'h0055, 16'h0000, 16'hCAFE, 1, 4, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ls_unit.md
# ls_unit

Load/store unit that answers memory-access requests issued by the global control FSM during load and store instruction states. Accepts one request at a time, drives a single synchronous memory/IO port with a ready handshake, returns read data, and pulses completion back to the FSM. Sits between the control FSM and the data RAM / memory-mapped IO bus.

## Interface
- ADDR_W, 16: memory address width; `ls_addr` is truncated to its low ADDR_W bits (1..16).
- DATA_W, 16: data word width.
- TIMEOUT, 15: maximum WAIT cycles without `mem_ready` before an error completion (used only with `LS_TIMEOUT_EN`).
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- ls_req  in  1  request valid; sampled only in IDLE.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  16  word address.
- ls_wdata  in  DATA_W  store data.
- ls_busy  out  1  high in every state except IDLE.
- ls_done  out  1  one-cycle completion pulse.
- ls_err  out  1  valid with `ls_done`; 1 = timed out.
- ls_rdata  out  DATA_W  last successfully loaded word; held between loads.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when `mem_ready` = 1.
- mem_ready  in  1  memory acknowledge for the current access.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if `ls_req` = 1, latch `ls_we`, `ls_addr[ADDR_W-1:0]`, `ls_wdata` and go to ISSUE; otherwise stay in IDLE.
- ISSUE: `mem_en` = 1, `mem_we` = latched we, address and data from latches; go to WAIT unconditionally. `mem_ready` is ignored in ISSUE.
- WAIT: `mem_en` = 0, `mem_we` = 0; `mem_addr`/`mem_wdata` hold the latched values. When `mem_ready` = 1: if a load, capture `mem_rdata` into `ls_rdata`; go to DONE with err = 0.
- DONE: `ls_done` = 1 for exactly one cycle, `ls_err` reflects the outcome; go to IDLE.
- `ls_req` is ignored outside IDLE; a request held high through DONE is accepted again in the following IDLE cycle.
- A store never modifies `ls_rdata`. A failed (timed-out) load leaves `ls_rdata` unchanged.
- Reset values: state = IDLE; `ls_busy`, `ls_done`, `ls_err`, `mem_en`, `mem_we` = 0; `ls_rdata`, `mem_addr`, `mem_wdata` and the latches = 0.
- An asserted reset in any state forces IDLE immediately and drops `mem_en`/`mem_we` asynchronously. No completion pulse is produced for the aborted access.

## Timing
- With `ls_req` sampled at edge 0, the state is ISSUE in cycle 1 and WAIT in cycle 2.
- If `mem_ready` = 1 in cycle 2, `ls_done` is high in cycle 3 and `ls_rdata` is updated at the start of cycle 3.
- Minimum request-to-request period is 4 cycles. Each cycle of `mem_ready` delay adds one cycle.
- All outputs are registered, or are decoded from state alone; none depends combinationally on inputs.

## Configuration
- `LS_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments in each WAIT cycle without `mem_ready`.
  - When the counter reaches TIMEOUT, the block goes to DONE with `ls_err` = 1.
  - `mem_ready` in the same cycle as the count reaching TIMEOUT wins: success, err = 0.
- `LS_TIMEOUT_EN` undefined: WAIT holds indefinitely, `ls_err` is constant 0, and no counter logic is built.

## Structure
- Shared package `cpu_pkg` holds the state encoding typedef `ls_state_t` and the default TIMEOUT constant.
- One sub-module: `ls_timeout_ctr` (clear, enable, terminal-count flag, width $clog2(TIMEOUT+1)). It is instantiated only under `LS_TIMEOUT_EN`.

## Test plan
- Load: `ls_req` = 1, `ls_we` = 0, `ls_addr` = 0x0012. Memory returns 0xBEEF with `mem_ready` in the first WAIT cycle. Required: `mem_en` for one cycle with `mem_addr` = 0x0012, `ls_done` 3 cycles after the request edge, `ls_rdata` = 0xBEEF, `ls_err` = 0.
- Store: `ls_we` = 1, addr 0x0040, wdata 0x1234, `mem_ready` delayed 3 cycles. Required: `mem_we` = `mem_en` = 1 for one cycle, `ls_done` 6 cycles after the request, `ls_rdata` unchanged.
- Back-to-back: `ls_req` held high for two loads (0xAAAA, then 0x5555). Required: requests accepted 4 cycles apart, and a request pulse arriving during WAIT is ignored.
- Timeout (`LS_TIMEOUT_EN`, TIMEOUT = 15): `mem_ready` never asserts. Required: `ls_done` with `ls_err` = 1 after 15 WAIT cycles, and `ls_rdata` keeps its prior value. A second run with `mem_ready` on exactly the 15th cycle must give err = 0.
- Reset mid-access: assert reset during WAIT. Required: `mem_en`/`mem_we`/`ls_busy` go to 0 without waiting for a clock edge, no `ls_done`, and `ls_rdata` = 0. After release, a new load completes normally.
